// File: rtl/blob_extraction.sv
// Colour-blob extractor: raster-scans an RGB frame, classifies pixels against a 32-slot colour
// table and writes one record per qualifying horizontal run. Optional debug taps: BLOB_DEBUG_EN.
module blob_extraction #(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 240,
    parameter logic [17:0] RESULT_BASE = 18'h20000,
    parameter int unsigned MIN_RUN     = 4,
    parameter int unsigned MAX_BLOBS   = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wren_primary_color_slots,
    input  logic [4:0]  address_primary_color_slots,
    input  logic [23:0] data_write_primary_color_slots,
    input  logic        pause,
    input  logic        enable_blob_extraction,
    input  logic [31:0] data_read,
    input  logic [7:0]  color_similarity_threshold,
    output logic        wren,
    output logic [31:0] data_write,
    output logic [17:0] address,
    output logic        blob_extraction_done,
    output logic [15:0] blob_count,
    output logic [15:0] debug0,
    output logic [15:0] debug1,
    output logic [3:0]  debug2,
    output logic [4:0]  debug3
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WAIT     = 3'd2,
        S_CLASSIFY = 3'd3,
        S_WRITE    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      state_q;
    logic [23:0] slot_rgb_q [32];
    logic [31:0] slot_vld_q;
    logic [8:0]  x_q, y_q;
    logic [17:0] pix_addr_q, address_q;
    logic [15:0] blob_count_q;
    logic        done_q;
    logic [23:0] pixel_q;
    logic        run_open_q, run_fg_q;
    logic [4:0]  run_slot_q;
    logic [8:0]  run_start_q;
    logic [31:0] rec_q, pend_rec_q;
    logic        pend_q;

    logic        pix_fg;
    logic [4:0]  pix_slot;
    logic [4:0]  idx;
    logic        same_run, qual_a, qual_b, write_a, write_b, adv;
    logic        last_col, last_row, room, room_next;
    logic [8:0]  new_start;
    logic [9:0]  len_a, len_b;
    logic [31:0] rec_a, rec_b;
    logic        unused_data_read;

    assign unused_data_read = ^data_read[31:24];

    function automatic logic chan_ok(input logic [7:0] a, input logic [7:0] b, input logic [7:0] t);
        logic [7:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return d <= t;
    endfunction

    // Descending scan so the lowest-index matching slot is the one left standing.
    always_comb begin
        pix_fg   = 1'b0;
        pix_slot = '0;
        idx      = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            idx = 5'(31 - k);
            if (slot_vld_q[idx] &&
                chan_ok(pixel_q[23:16], slot_rgb_q[idx][23:16], color_similarity_threshold) &&
                chan_ok(pixel_q[15:8],  slot_rgb_q[idx][15:8],  color_similarity_threshold) &&
                chan_ok(pixel_q[7:0],   slot_rgb_q[idx][7:0],   color_similarity_threshold)) begin
                pix_fg   = 1'b1;
                pix_slot = idx;
            end
        end
    end

    always_comb begin
        last_col  = (32'(x_q) == WIDTH - 1);
        last_row  = (32'(y_q) == HEIGHT - 1);
        room      = (32'(blob_count_q) < MAX_BLOBS);
        room_next = (32'(blob_count_q) + 32'd1 < MAX_BLOBS);
        same_run  = run_open_q && (run_fg_q == pix_fg) && (!pix_fg || run_slot_q == pix_slot);
        new_start = same_run ? run_start_q : x_q;
        len_a     = {1'b0, x_q} - {1'b0, run_start_q};
        len_b     = {1'b0, x_q} - {1'b0, new_start} + 10'd1;
        qual_a    = run_fg_q && (32'(len_a) >= MIN_RUN);
        qual_b    = pix_fg && (32'(len_b) >= MIN_RUN);
        rec_a     = {run_slot_q, y_q, run_start_q, x_q - 9'd1};
        rec_b     = {pix_slot, y_q, new_start, x_q};
        write_a   = run_open_q && !same_run && qual_a && room;
        write_b   = !write_a && last_col && qual_b && room;
        adv       = ((state_q == S_CLASSIFY) && !write_a && !write_b) ||
                    ((state_q == S_WRITE) && !(pend_q && room_next));
    end

    always_ff @(posedge clk) begin
        if (wren_primary_color_slots)
            slot_rgb_q[address_primary_color_slots] <= data_write_primary_color_slots;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= '0;
        end else if (wren_primary_color_slots) begin
            slot_vld_q[address_primary_color_slots] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            pix_addr_q   <= '0;
            address_q    <= '0;
            blob_count_q <= '0;
            done_q       <= 1'b0;
            pixel_q      <= '0;
            run_open_q   <= 1'b0;
            run_fg_q     <= 1'b0;
            run_slot_q   <= '0;
            run_start_q  <= '0;
            rec_q        <= '0;
            pend_rec_q   <= '0;
            pend_q       <= 1'b0;
        end else if (state_q != S_IDLE && !enable_blob_extraction) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else if (!pause) begin
            case (state_q)
                S_IDLE: begin
                    if (enable_blob_extraction) begin
                        state_q      <= S_READ;
                        x_q          <= '0;
                        y_q          <= '0;
                        pix_addr_q   <= '0;
                        address_q    <= '0;
                        blob_count_q <= '0;
                        run_open_q   <= 1'b0;
                        pend_q       <= 1'b0;
                    end
                end
                S_READ: state_q <= S_WAIT;
                S_WAIT: begin
                    pixel_q <= data_read[23:0];
                    state_q <= S_CLASSIFY;
                end
                S_CLASSIFY: begin
                    run_open_q  <= 1'b1;
                    run_fg_q    <= pix_fg;
                    run_slot_q  <= pix_slot;
                    run_start_q <= new_start;
                    // A slot change on the last column can close two runs; the second is queued.
                    if (write_a) begin
                        rec_q      <= rec_a;
                        pend_rec_q <= rec_b;
                        pend_q     <= last_col && qual_b;
                        address_q  <= RESULT_BASE + 18'(blob_count_q);
                        state_q    <= S_WRITE;
                    end else if (write_b) begin
                        rec_q     <= rec_b;
                        pend_q    <= 1'b0;
                        address_q <= RESULT_BASE + 18'(blob_count_q);
                        state_q   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    blob_count_q <= blob_count_q + 16'd1;
                    if (pend_q && room_next) begin
                        rec_q     <= pend_rec_q;
                        pend_q    <= 1'b0;
                        address_q <= RESULT_BASE + 18'(blob_count_q) + 18'd1;
                    end
                end
                S_DONE: done_q <= 1'b1;
                default: state_q <= S_IDLE;
            endcase
            if (adv) begin
                pix_addr_q <= pix_addr_q + 18'd1;
                address_q  <= pix_addr_q + 18'd1;
                pend_q     <= 1'b0;
                if (last_col) begin
                    x_q        <= '0;
                    run_open_q <= 1'b0;
                    if (last_row) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        y_q     <= y_q + 9'd1;
                        state_q <= S_READ;
                    end
                end else begin
                    x_q     <= x_q + 9'd1;
                    state_q <= S_READ;
                end
            end
        end
    end

    assign wren                 = (state_q == S_WRITE) && !pause && enable_blob_extraction;
    assign data_write           = wren ? rec_q : '0;
    assign address              = address_q;
    assign blob_extraction_done = done_q;
    assign blob_count           = blob_count_q;

`ifdef BLOB_DEBUG_EN
    logic [4:0] last_slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_slot_q <= '0;
            debug0      <= '0;
            debug1      <= '0;
            debug2      <= '0;
            debug3      <= '0;
        end else begin
            if (state_q == S_CLASSIFY && !pause && enable_blob_extraction)
                last_slot_q <= pix_fg ? pix_slot : 5'd31;
            debug0 <= {7'd0, y_q};
            debug1 <= {7'd0, x_q};
            debug2 <= {1'b0, state_q};
            debug3 <= last_slot_q;
        end
    end
`else
    assign debug0 = '0;
    assign debug1 = '0;
    assign debug2 = '0;
    assign debug3 = '0;
`endif

endmodule

// File: tb/tb_blob_extraction.sv
// Directed bench for blob_extraction on a reduced 32x6 frame: table of scan scenarios plus
// reset-mid-scan, pause and abort sequences.
module tb_blob_extraction;

    localparam int          W    = 32;
    localparam int          H    = 6;
    localparam int          NPIX = W * H;
    localparam logic [17:0] RB   = 18'h20000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren_ps;
    logic [4:0]  addr_ps;
    logic [23:0] data_ps;
    logic        pause;
    logic        enable;
    logic [31:0] data_read;
    logic [7:0]  thr;
    logic        wren;
    logic [31:0] data_write;
    logic [17:0] address;
    logic        done;
    logic [15:0] blob_count;
    logic [15:0] debug0, debug1;
    logic [3:0]  debug2;
    logic [4:0]  debug3;

    blob_extraction #(
        .WIDTH(W),
        .HEIGHT(H),
        .RESULT_BASE(RB),
        .MIN_RUN(4),
        .MAX_BLOBS(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wren_primary_color_slots(wren_ps),
        .address_primary_color_slots(addr_ps),
        .data_write_primary_color_slots(data_ps),
        .pause(pause),
        .enable_blob_extraction(enable),
        .data_read(data_read),
        .color_similarity_threshold(thr),
        .wren(wren),
        .data_write(data_write),
        .address(address),
        .blob_extraction_done(done),
        .blob_count(blob_count),
        .debug0(debug0),
        .debug1(debug1),
        .debug2(debug2),
        .debug3(debug3)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [0:NPIX-1];
    logic [17:0] wa_q [$];
    logic [31:0] wd_q [$];

    always @(posedge clk) begin
        data_read <= (address < 18'(NPIX)) ? {8'h00, mem[address[7:0]]} : 32'h0;
        if (wren) begin
            wa_q.push_back(address);
            wd_q.push_back(data_write);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int s, input int y, input int xs, input int xe);
        return {5'(s), 9'(y), 9'(xs), 9'(xe)};
    endfunction

    typedef struct {
        logic [4:0]  sa;
        logic [23:0] ca;
        logic [4:0]  sb;
        logic [23:0] cb;
        logic [7:0]  t;
        int          ry;
        int          ax0, ax1;
        logic [23:0] pa;
        int          bx0, bx1;
        logic [23:0] pb;
        int          exp_n;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t vt [7];

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        pause   = 1'b0;
        wren_ps = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic wslot(input logic [4:0] i, input logic [23:0] c);
        @(negedge clk);
        wren_ps = 1'b1;
        addr_ps = i;
        data_ps = c;
        @(negedge clk);
        wren_ps = 1'b0;
    endtask

    task automatic setup(input vec_t v);
        do_reset();
        for (int i = 0; i < NPIX; i++) mem[i] = 24'h0;
        for (int x = v.ax0; x <= v.ax1 && v.ax0 >= 0; x++) mem[v.ry * W + x] = v.pa;
        for (int x = v.bx0; x <= v.bx1 && v.bx0 >= 0; x++) mem[v.ry * W + x] = v.pb;
        wslot(v.sa, v.ca);
        wslot(v.sb, v.cb);
        thr = v.t;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_recs(input string tag, input vec_t v);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_count"}, 32'(blob_count), 32'(v.exp_n));
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < wa_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(RB) + 32'(i));
            chk($sformatf("%s_rec%0d", tag, i), wd_q[i], (i == 0) ? v.e0 : v.e1);
        end
    endtask

    initial begin
        int          n;
        int          viol;
        logic [17:0] a0;

        rst_n = 1'b0; wren_ps = 1'b0; addr_ps = '0; data_ps = '0;
        pause = 1'b0; enable = 1'b0; thr = '0;

        vt[0] = '{5'd0, 24'hFF0000, 5'd0, 24'hFF0000, 8'd8, 0, 10, 19, 24'hF80808, -1, -1, 24'h0, 1, mk(0,0,10,19), 32'h0};
        vt[1] = '{5'd0, 24'hFF0000, 5'd0, 24'hFF0000, 8'd8, 0, 10, 19, 24'hF00000, -1, -1, 24'h0, 0, 32'h0, 32'h0};
        vt[2] = '{5'd2, 24'h00FF00, 5'd5, 24'h00FF00, 8'd0, 3, 0, 31, 24'h00FF00, -1, -1, 24'h0, 1, mk(2,3,0,31), 32'h0};
        vt[3] = '{5'd1, 24'h0000FF, 5'd1, 24'h0000FF, 8'd0, 1, 5, 7, 24'h0000FF, -1, -1, 24'h0, 0, 32'h0, 32'h0};
        vt[4] = '{5'd1, 24'h112233, 5'd3, 24'h445566, 8'd4, 2, 0, 4, 24'h112233, 5, 9, 24'h445566, 2, mk(1,2,0,4), mk(3,2,5,9)};
        vt[5] = '{5'd7, 24'h0A0B0C, 5'd7, 24'h0A0B0C, 8'd0, 5, 28, 31, 24'h0A0B0C, -1, -1, 24'h0, 1, mk(7,5,28,31), 32'h0};
        vt[6] = '{5'd4, 24'h808080, 5'd9, 24'h848484, 8'd4, 4, 3, 8, 24'h828282, -1, -1, 24'h0, 1, mk(4,4,3,8), 32'h0};

        #1;
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(blob_count), 32'd0);

        for (int i = 0; i < 7; i++) begin
            setup(vt[i]);
            @(negedge clk);
            enable = 1'b1;
            wait_done(3000);
            check_recs($sformatf("vec%0d", i), vt[i]);
            enable = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_done_clr", i), 32'(done), 32'd0);
        end

        // Reset in the middle of a scan, after one record has been written.
        setup(vt[0]);
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (wa_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_first_write", 32'(wa_q.size()), 32'd1);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(blob_count), 32'd0);
        chk("mid_rst_addr", 32'(address), 32'd0);
        chk("mid_rst_wren", 32'(wren), 32'd0);
        chk("mid_rst_data", data_write, 32'd0);
        chk("mid_rst_dbg", {debug0, 11'd0, debug3}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
        wslot(vt[0].sa, vt[0].ca);
        @(negedge clk);
        enable = 1'b1;
        wait_done(3000);
        check_recs("restart", vt[0]);
        enable = 1'b0;

        // Pause: held pause freezes address and wren, then random pausing must not alter records.
        setup(vt[4]);
        @(negedge clk);
        enable = 1'b1;
        repeat (30) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        a0   = address;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (address !== a0 || wren !== 1'b0) viol++;
        end
        chk("pause_hold", 32'(viol), 32'd0);
        viol = 0;
        n    = 0;
        while (!done && n < 6000) begin
            pause = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (pause && wren) viol++;
            n++;
        end
        pause = 1'b0;
        chk("pause_no_wren", 32'(viol), 32'd0);
        check_recs("paused", vt[4]);
        enable = 1'b0;

        // Abort after the first record: back to IDLE, count kept, no done.
        setup(vt[0]);
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (wa_q.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        a0 = address;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wren", 32'(wren), 32'd0);
        chk("abort_count", 32'(blob_count), 32'd1);
        repeat (10) @(negedge clk);
        chk("abort_idle_addr", 32'(address), 32'(a0));
        chk("abort_idle_done", 32'(done), 32'd0);
        wa_q.delete();
        wd_q.delete();
        enable = 1'b1;
        wait_done(3000);
        check_recs("after_abort", vt[0]);
        enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
